mc_controller_fsm_v2: RTL and testbench

- Parametrised next-generation main controller FSM for the multi-cycle RV32I core.
- Adds a memory request/ready handshake with wait states and timeout, plus JALR and AUIPC sequencing.
- Adds a sticky trap state for illegal opcodes and bus timeouts.
- Drives the datapath muxes and enables, and sits beside the ALU decoder inside the controller.

---
 rtl/mc_controller_fsm_v2_pkg.sv | 65 ++++++
 rtl/mc_controller_fsm_v2_wait_timer.sv | 50 +++++
 rtl/mc_controller_fsm_v2.sv | 224 ++++++++++++++++++++++
 tb/tb_mc_controller_fsm_v2.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_controller_fsm_v2_pkg.sv
// mc_controller_fsm_v2_pkg
// Shared definitions for the multi-cycle RV32I main controller:
//   - statetype: 4-bit FSM state encoding (15 states, one code unused)
//   - opcodetype constants for the nine supported opcodes
//   - trap cause codes
//   - datapath mux select encodings (ALUSrcA, ALUSrcB, ResultSrc) and aluOP classes
package mc_controller_fsm_v2_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_EXECUTER = 4'd5,
    S_EXECUTEI = 4'd6,
    S_JALR_ADR = 4'd7,
    S_JAL      = 4'd8,
    S_AUIPC    = 4'd9,
    S_LUI      = 4'd10,
    S_BEQ      = 4'd11,
    S_ALUWB    = 4'd12,
    S_MEMWB    = 4'd13,
    S_TRAP     = 4'd14
  } statetype;

  typedef logic [6:0] opcodetype;

  localparam opcodetype OPC_LW    = 7'b0000011;
  localparam opcodetype OPC_SW    = 7'b0100011;
  localparam opcodetype OPC_RTYPE = 7'b0110011;
  localparam opcodetype OPC_ITYPE = 7'b0010011;
  localparam opcodetype OPC_JAL   = 7'b1101111;
  localparam opcodetype OPC_JALR  = 7'b1100111;
  localparam opcodetype OPC_BEQ   = 7'b1100011;
  localparam opcodetype OPC_LUI   = 7'b0110111;
  localparam opcodetype OPC_AUIPC = 7'b0010111;

  localparam logic [1:0] TRAP_NONE    = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
  localparam logic [1:0] TRAP_BUS_TMO = 2'b10;

  localparam logic [1:0] ALUSRCA_PC    = 2'b00;
  localparam logic [1:0] ALUSRCA_OLDPC = 2'b01;
  localparam logic [1:0] ALUSRCA_RD1   = 2'b10;

  localparam logic [1:0] ALUSRCB_RD2  = 2'b00;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b01;
  localparam logic [1:0] ALUSRCB_FOUR = 2'b10;

  localparam logic [1:0] RESULTSRC_ALUOUT = 2'b00;
  localparam logic [1:0] RESULTSRC_DATA   = 2'b01;
  localparam logic [1:0] RESULTSRC_ALURES = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  // States that hold a memory request open until mem_ready.
  function automatic logic is_mem_state(statetype s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_controller_fsm_v2_wait_timer.sv
// mc_wait_timer
// Counts consecutive cycles in which a memory request is open but not yet
// answered, and flags a bus timeout on the last allowed wait cycle.
// Ports:
//   clk, reset (async, active-low)
//   active    : a memory request is open this cycle
//   mem_ready : memory completes the access this cycle
//   timeout   : waiting any longer would exceed MEM_TIMEOUT cycles
// MEM_TIMEOUT = 0 disables the timeout.
module mc_wait_timer
  import mc_controller_fsm_v2_pkg::*;
#(
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(MEM_TIMEOUT - 1);

  logic [TMO_W-1:0] count;
  logic             waiting;

  assign waiting = active && !mem_ready;

  // A ready on the limit cycle masks the timeout so the access completes.
  generate
    if (MEM_TIMEOUT != 0) begin : g_tmo
      assign timeout = waiting && (count == LIMIT);
    end else begin : g_no_tmo
      assign timeout = 1'b0;
    end
  endgenerate

  // The FSM leaves the wait state on ready or on timeout, so both clear the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (waiting && !timeout) begin
      count <= count + TMO_W'(1);
    end else begin
      count <= '0;
    end
  end

endmodule

// File: rtl/mc_controller_fsm_v2.sv
// mc_controller_fsm_v2
// Main controller FSM for the multi-cycle RV32I core with a memory
// request/ready handshake, bus timeout, JALR/AUIPC sequencing and a sticky
// trap state.
// Ports:
//   clk, reset (async, active-low), op (opcode), mem_ready, trap_clear
//   ALUSrcA/ALUSrcB/ResultSrc : datapath mux selects
//   AdrSrc/IRWrite/RegWrite/MemWrite/Branch/PCUpdate : datapath enables
//   aluOP : ALU decoder class; mem_req : memory request
//   trap/trap_cause : trap state and its cause
//   cycle_cnt/instret_cnt : performance counters
// Build option: define CTRL_PERF_CNT_EN to implement the performance
// counters; otherwise both counter outputs are tied to zero.
module mc_controller_fsm_v2
  import mc_controller_fsm_v2_pkg::*;
#(
  parameter int OP_W        = 7,
  parameter int ALUOP_W     = 2,
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  input  logic               trap_clear,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               Branch,
  output logic               PCUpdate,
  output logic [ALUOP_W-1:0] aluOP,
  output logic               mem_req,
  output logic               trap,
  output logic [1:0]         trap_cause,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instret_cnt
);

  statetype   state;
  statetype   state_next;
  logic [1:0] cause_next;
  logic       timeout;

  mc_wait_timer #(
    .TMO_W       (TMO_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (mem_req),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  // Next state; mem_ready is tested before timeout so a late ready wins.
  always_comb begin
    state_next = state;
    cause_next = trap_cause;
    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = TRAP_BUS_TMO;
        end
      end
      S_DECODE: begin
        case (op)
          OP_W'(OPC_LW), OP_W'(OPC_SW): state_next = S_MEMADR;
          OP_W'(OPC_RTYPE):             state_next = S_EXECUTER;
          OP_W'(OPC_ITYPE):             state_next = S_EXECUTEI;
          OP_W'(OPC_JAL):               state_next = S_JAL;
          OP_W'(OPC_JALR):              state_next = S_JALR_ADR;
          OP_W'(OPC_BEQ):               state_next = S_BEQ;
          OP_W'(OPC_LUI):               state_next = S_LUI;
          OP_W'(OPC_AUIPC):             state_next = S_AUIPC;
          default: begin
            state_next = S_TRAP;
            cause_next = TRAP_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:   state_next = (op == OP_W'(OPC_LW)) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_ready) begin
          state_next = S_MEMWB;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = TRAP_BUS_TMO;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_next = S_FETCH;
        end else if (timeout) begin
          state_next = S_TRAP;
          cause_next = TRAP_BUS_TMO;
        end
      end
      S_JALR_ADR: state_next = S_JAL;
      S_EXECUTER, S_EXECUTEI, S_JAL, S_LUI, S_AUIPC: state_next = S_ALUWB;
      S_BEQ, S_ALUWB, S_MEMWB: state_next = S_FETCH;
      S_TRAP: begin
        if (trap_clear) begin
          state_next = S_FETCH;
          cause_next = TRAP_NONE;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      trap_cause <= TRAP_NONE;
    end else begin
      state      <= state_next;
      trap_cause <= cause_next;
    end
  end

  // Moore output decode; only IRWrite/PCUpdate in S_FETCH look at mem_ready.
  always_comb begin
    ALUSrcA   = ALUSRCA_PC;
    ALUSrcB   = ALUSRCB_RD2;
    ResultSrc = RESULTSRC_ALUOUT;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    Branch    = 1'b0;
    PCUpdate  = 1'b0;
    aluOP     = ALUOP_W'(ALUOP_ADD);
    mem_req   = is_mem_state(state);
    trap      = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = ALUSRCB_FOUR;
        ResultSrc = RESULTSRC_ALURES;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = ALUSRCA_OLDPC;
        ALUSrcB = ALUSRCB_IMM;
      end
      S_MEMADR, S_JALR_ADR: begin
        ALUSrcA = ALUSRCA_RD1;
        ALUSrcB = ALUSRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = ALUSRCA_RD1;
        aluOP   = ALUOP_W'(ALUOP_FUNCT);
      end
      S_EXECUTEI: begin
        ALUSrcA = ALUSRCA_RD1;
        ALUSrcB = ALUSRCB_IMM;
        aluOP   = ALUOP_W'(ALUOP_FUNCT);
      end
      S_JAL: begin
        ALUSrcA  = ALUSRCA_OLDPC;
        ALUSrcB  = ALUSRCB_FOUR;
        PCUpdate = 1'b1;
      end
      S_AUIPC: begin
        ALUSrcA = ALUSRCA_OLDPC;
        ALUSrcB = ALUSRCB_IMM;
      end
      S_LUI: begin
        ALUSrcB = ALUSRCB_IMM;
        aluOP   = ALUOP_W'(ALUOP_LUI);
      end
      S_BEQ: begin
        ALUSrcA = ALUSRCA_RD1;
        aluOP   = ALUOP_W'(ALUOP_SUB);
        Branch  = 1'b1;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_MEMWB: begin
        ResultSrc = RESULTSRC_DATA;
        RegWrite  = 1'b1;
      end
      S_TRAP: trap = 1'b1;
      default: ;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  // An instruction retires when it hands control back to fetch; leaving
  // the trap state is not a retirement.
  logic retire;
  assign retire = (state == S_ALUWB) || (state == S_MEMWB) || (state == S_BEQ) ||
                  ((state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire) begin
        instret_cnt <= instret_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_controller_fsm_v2.sv
// Testbench for mc_controller_fsm_v2: directed scenarios followed by random
// instruction streams, compared every cycle against an instruction-level
// reference model (each opcode expands to a list of micro-steps).
module tb_mc_controller_fsm_v2;

  localparam int TMO = 15;

  logic        clk;
  logic        reset;
  logic [6:0]  op;
  logic        mem_ready;
  logic        trap_clear;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic        AdrSrc, IRWrite, RegWrite, MemWrite, Branch, PCUpdate;
  logic [1:0]  aluOP;
  logic        mem_req, trap;
  logic [1:0]  trap_cause;
  logic [31:0] cycle_cnt, instret_cnt;

  mc_controller_fsm_v2 #(
    .OP_W(7), .ALUOP_W(2), .TMO_W(4), .MEM_TIMEOUT(TMO), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .trap_clear(trap_clear),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .Branch(Branch), .PCUpdate(PCUpdate), .aluOP(aluOP), .mem_req(mem_req),
    .trap(trap), .trap_cause(trap_cause), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, ADD = 7'b0110011,
                         ADDI = 7'b0010011, JAL = 7'b1101111, JALR = 7'b1100111,
                         BEQ = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                         BAD = 7'b1111111;

  // {A, B, Result, AdrSrc, IRWrite, RegWrite, MemWrite, Branch, PCUpdate, aluOP, mem_req, trap, cause}
  localparam logic [17:0] RESET_VEC = {2'b00, 2'b10, 2'b10, 6'b000000, 2'b00, 1'b1, 1'b0, 2'b00};

  // Micro-step kinds of the reference model.
  localparam int K_FETCH = 0, K_DECODE = 1, K_ADDR = 2, K_LOAD = 3, K_STORE = 4,
                 K_ALU_R = 5, K_ALU_I = 6, K_JALR = 7, K_LINK = 8, K_AUIPC = 9,
                 K_LUI = 10, K_BRANCH = 11, K_WB_ALU = 12, K_WB_MEM = 13, K_TRAP = 14;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          m_cur;
  int          m_prog[$];
  int          m_wc;
  logic [1:0]  m_tc;
  logic [31:0] m_cyc, m_ret;
  logic [17:0] outs_vec;

  assign outs_vec = {ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, IRWrite, RegWrite, MemWrite,
                     Branch, PCUpdate, aluOP, mem_req, trap, trap_cause};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] expect_outs(input int k, input logic rdy, input logic [1:0] tc);
    logic [1:0] a, b, r, aop;
    logic adr, irw, rw, mw, br, pcu, mreq, trp;
    a = 0; b = 0; r = 0; aop = 0; adr = 0; irw = 0; rw = 0; mw = 0;
    br = 0; pcu = 0; mreq = 0; trp = 0;
    case (k)
      K_FETCH:  begin mreq = 1; b = 2; r = 2; irw = rdy; pcu = rdy; end
      K_DECODE: begin a = 1; b = 1; end
      K_ADDR:   begin a = 2; b = 1; end
      K_LOAD:   begin mreq = 1; adr = 1; end
      K_STORE:  begin mreq = 1; adr = 1; mw = 1; end
      K_ALU_R:  begin a = 2; aop = 2; end
      K_ALU_I:  begin a = 2; b = 1; aop = 2; end
      K_JALR:   begin a = 2; b = 1; end
      K_LINK:   begin a = 1; b = 2; pcu = 1; end
      K_AUIPC:  begin a = 1; b = 1; end
      K_LUI:    begin b = 1; aop = 3; end
      K_BRANCH: begin a = 2; aop = 1; br = 1; end
      K_WB_ALU: rw = 1;
      K_WB_MEM: begin r = 1; rw = 1; end
      K_TRAP:   trp = 1;
      default: ;
    endcase
    return {a, b, r, adr, irw, rw, mw, br, pcu, aop, mreq, trp, tc};
  endfunction

  function automatic logic [63:0] expect_cnts();
`ifdef CTRL_PERF_CNT_EN
    return {m_cyc, m_ret};
`else
    return 64'd0;
`endif
  endfunction

  task automatic model_reset();
    m_cur = K_FETCH; m_prog.delete(); m_wc = 0; m_tc = 2'b00; m_cyc = 0; m_ret = 0;
  endtask

  // Move to the next micro-step; an exhausted program retires the instruction.
  task automatic next_step();
    if (m_prog.size() == 0) begin
      m_cur = K_FETCH;
      m_ret++;
    end else begin
      m_cur = m_prog.pop_front();
    end
  endtask

  task automatic model_step(input logic [6:0] o, input logic rdy, input logic tclr);
    m_cyc++;
    case (m_cur)
      K_FETCH, K_LOAD, K_STORE: begin
        if (rdy) begin
          m_wc = 0;
          if (m_cur == K_FETCH) m_cur = K_DECODE;
          else next_step();
        end else if (m_wc == TMO - 1) begin
          m_cur = K_TRAP; m_tc = 2'b10; m_wc = 0; m_prog.delete();
        end else begin
          m_wc++;
        end
      end
      K_DECODE: begin
        m_prog.delete();
        case (o)
          LW:    m_prog = '{K_ADDR, K_LOAD, K_WB_MEM};
          SW:    m_prog = '{K_ADDR, K_STORE};
          ADD:   m_prog = '{K_ALU_R, K_WB_ALU};
          ADDI:  m_prog = '{K_ALU_I, K_WB_ALU};
          JAL:   m_prog = '{K_LINK, K_WB_ALU};
          JALR:  m_prog = '{K_JALR, K_LINK, K_WB_ALU};
          BEQ:   m_prog = '{K_BRANCH};
          LUI:   m_prog = '{K_LUI, K_WB_ALU};
          AUIPC: m_prog = '{K_AUIPC, K_WB_ALU};
          default: ;
        endcase
        if (m_prog.size() == 0) begin
          m_cur = K_TRAP; m_tc = 2'b01;
        end else begin
          m_cur = m_prog.pop_front();
        end
      end
      K_TRAP: if (tclr) begin m_cur = K_FETCH; m_tc = 2'b00; end
      default: next_step();
    endcase
  endtask

  task automatic drive_check_step(input string tag, input logic [6:0] o, input logic r, input logic tc);
    op = o; mem_ready = r; trap_clear = tc;
    #2;
    check(tag, {46'd0, outs_vec}, {46'd0, expect_outs(m_cur, r, m_tc)});
    check({tag, "_cnt"}, {cycle_cnt, instret_cnt}, expect_cnts());
    model_step(o, r, tc);
  endtask

  task automatic cycle(input string tag, input logic [6:0] o, input logic r, input logic tc);
    @(negedge clk);
    drive_check_step(tag, o, r, tc);
  endtask

  task automatic reset_hold(input string tag);
    @(negedge clk);
    #2;
    check(tag, {46'd0, outs_vec}, {46'd0, RESET_VEC});
    check({tag, "_cnt"}, {cycle_cnt, instret_cnt}, 64'd0);
  endtask

  task automatic reset_release(input string tag, input logic [6:0] o);
    @(negedge clk);
    reset = 1'b1;
    drive_check_step(tag, o, 1'b1, 1'b0);
  endtask

  function automatic logic [6:0] random_op();
    logic [6:0] legal [9];
    logic [6:0] o;
    logic hit;
    legal = '{LW, SW, ADD, ADDI, JAL, JALR, BEQ, LUI, AUIPC};
    if ($urandom_range(0, 9) != 0) return legal[$urandom_range(0, 8)];
    do begin
      o = 7'($urandom);
      hit = 1'b0;
      for (int i = 0; i < 9; i++) if (legal[i] == o) hit = 1'b1;
    end while (hit);
    return o;
  endfunction

  initial begin
    logic [6:0] rop;
    reset = 1'b0; op = 7'd0; mem_ready = 1'b0; trap_clear = 1'b0;
    model_reset();
    reset_hold("reset_a");
    reset_hold("reset_b");

    // add with ready always high: FETCH, DECODE, EXECUTER, ALUWB
    reset_release("add_fetch", ADD);
    cycle("add_decode", ADD, 1'b1, 1'b0);
    cycle("add_exec", ADD, 1'b1, 1'b0);
    cycle("add_wb", ADD, 1'b1, 1'b0);

    // lw with three wait cycles in the read
    for (int i = 0; i < 3; i++) cycle("lw_front", LW, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("lw_wait", LW, 1'b0, 1'b0);
    cycle("lw_ready", LW, 1'b1, 1'b0);
    cycle("lw_wb", LW, 1'b1, 1'b0);

    // lw whose ready arrives on the timeout cycle: the read completes
    for (int i = 0; i < 3; i++) cycle("lw2_front", LW, 1'b1, 1'b0);
    for (int i = 0; i < TMO - 1; i++) cycle("lw2_wait", LW, 1'b0, 1'b0);
    cycle("lw2_late_ready", LW, 1'b1, 1'b0);
    cycle("lw2_wb", LW, 1'b1, 1'b0);

    // jalr with a two-cycle fetch stall
    cycle("jalr_fetch_wait", JALR, 1'b0, 1'b0);
    cycle("jalr_fetch_wait", JALR, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle("jalr_seq", JALR, 1'b1, 1'b0);

    // sw never acknowledged: bus timeout trap
    for (int i = 0; i < 3; i++) cycle("sw_front", SW, 1'b1, 1'b0);
    for (int i = 0; i < TMO; i++) cycle("sw_wait", SW, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("sw_tmo_trap", {60'd0, trap, MemWrite, trap_cause}, {60'd0, 1'b1, 1'b0, 2'b10});
    cycle("sw_trap_clear", SW, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("sw_cause_cleared", {62'd0, trap_cause}, 64'd0);

    // illegal opcode: sticky trap for 20 cycles
    cycle("bad_fetch", BAD, 1'b1, 1'b0);
    cycle("bad_decode", BAD, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle("bad_hold", BAD, $urandom_range(0, 1) == 1, 1'b0);
    check("bad_cause", {62'd0, trap_cause}, {62'd0, 2'b01});
    cycle("bad_clear", BAD, 1'b0, 1'b1);

    // random instruction stream
    rop = ADD;
    for (int i = 0; i < 600; i++) begin
      if (m_cur == K_FETCH) rop = random_op();
      cycle("random", rop, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
    end
    // return to fetch before the reset scenario
    for (int i = 0; i < 40 && m_cur != K_FETCH; i++) cycle("drain", ADD, 1'b1, 1'b1);

    // reset asserted in the middle of a stalled store
    for (int i = 0; i < 3; i++) cycle("rst_sw_front", SW, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("rst_sw_wait", SW, 1'b0, 1'b0);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_mid_outs", {46'd0, outs_vec}, {46'd0, RESET_VEC});
    check("rst_mid_cnt", {cycle_cnt, instret_cnt}, 64'd0);
    model_reset();
    reset_hold("rst_mid_hold");
    reset_release("rst_after_fetch", ADD);
    for (int i = 0; i < 3; i++) cycle("rst_after_add", ADD, 1'b1, 1'b0);
    cycle("rst_after_next", BEQ, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
